// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexes a 4-digit BCD value onto a registered seven-segment
// decoder input and drives the active-low anodes one cycle later, so the
// anodes line up with the decoder's registered output.
// Optional feature macro: SSEG_LZ_BLANK_EN enables leading-zero suppression
// on digits 3..1 (digit 0 is always shown).
//
// Handshake: load is a request that is accepted on a rising edge only while
// ready=1. An accepted value is parked in pend, and ready drops the next
// cycle. A load while ready=0 is dropped silently. The parked value moves to
// the displayed register at the next frame boundary (last cycle of digit 3),
// and ready returns high the cycle after that transfer.
module seven_seg_scan_ctrl #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] bcd_in,
    output logic        ready,
    output logic [3:0]  bcd_seg,
    output logic [3:0]  an
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   active;
    logic [15:0]   pend;
    logic          pend_v;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic          xfer;
    logic [1:0]    dig_nxt;
    logic [15:0]   active_nxt;
    logic [3:0]    seg_nxt;

    // Select the nibble for digit d, blanking leading zeros when enabled.
    function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] d);
        logic [3:0] n;
        logic       blank;
        n     = v[{d, 2'b00} +: 4];
        blank = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
        case (d)
            2'd3:    blank = (v[15:12] == 4'h0);
            2'd2:    blank = (v[15:8]  == 8'h00);
            2'd1:    blank = (v[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        return blank ? 4'hF : n;
    endfunction

    // Slot timing, handshake decisions and the next value to present.
    always_comb begin
        tick       = (cnt == CW'(DIV - 1));
        boundary   = tick && (dig == 2'd3);
        accept     = load && ready;
        xfer       = boundary && pend_v;
        dig_nxt    = tick ? dig + 2'd1 : dig;
        active_nxt = xfer ? pend : active;
        seg_nxt    = pick_nibble(active_nxt, dig_nxt);
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= 2'd0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            dig <= dig_nxt;
        end
    end

    // Pending buffer, displayed value and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 16'h0000;
            pend   <= 16'h0000;
            pend_v <= 1'b0;
            ready  <= 1'b1;
        end else begin
            active <= active_nxt;
            if (xfer) begin
                pend_v <= 1'b0;
                ready  <= 1'b1;
            end else if (accept) begin
                pend   <= bcd_in;
                pend_v <= 1'b1;
                ready  <= 1'b0;
            end
        end
    end

    // Decoder input now; anode for the digit presented last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_seg <= 4'h0;
            an      <= 4'b1111;
        end else begin
            bcd_seg <= seg_nxt;
            an      <= ~(4'b0001 << dig);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with DIV=4: directed handshake cases followed
// by random loads, checked each cycle against a timeline reference model.
module tb_seven_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        ready;
    logic [3:0]  bcd_seg;
    logic [3:0]  an;

    int n_checks;
    int n_errors;

    // Reference state: k = edges since reset release, shown = displayed value,
    // exp_q = accepted values not yet on the display (at most one).
    int          k;
    logic [15:0] shown;
    logic [15:0] exp_q[$];

    seven_seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .bcd_seg (bcd_seg),
        .an      (an)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d: got %h expected %h", tag, k, act, exp);
        end
    endtask

    // Nibble shown for digit d of value v, with optional leading-zero blanking.
    function automatic logic [3:0] disp_digit(input logic [15:0] v, input int d);
        logic [15:0] hi;
        hi = v >> (4 * d);
`ifdef SSEG_LZ_BLANK_EN
        if (d > 0 && hi == 16'h0000) return 4'hF;
`endif
        return hi[3:0];
    endfunction

    task automatic model_reset();
        k     = 0;
        shown = 16'h0000;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic model_step();
        bit at_boundary;
        bit accepted;
        at_boundary = (k % FRAME) == FRAME - 1;
        accepted    = load && (exp_q.size() == 0);
        if (at_boundary && exp_q.size() != 0) shown = exp_q.pop_front();
        if (accepted) exp_q.push_back(bcd_in);
        k++;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_an;
        logic [3:0] exp_seg;
        if (k == 0) begin
            exp_an  = 4'b1111;
            exp_seg = 4'h0;
        end else begin
            exp_an  = ~(4'b0001 << (((k - 1) / DIV) % 4));
            exp_seg = disp_digit(shown, (k / DIV) % 4);
        end
        check_val("ready",   {15'd0, ready}, {15'd0, exp_q.size() == 0});
        check_val("an",      {12'd0, an},      {12'd0, exp_an});
        check_val("bcd_seg", {12'd0, bcd_seg}, {12'd0, exp_seg});
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Driver: directed loads in the first run, random loads afterwards.
    task automatic drive_inputs(input int run);
        load   = 1'b0;
        bcd_in = rand_bcd();
        if (run == 0) begin
            case (k)
                5:   begin load = 1'b1; bcd_in = 16'h1234; end
                7:   begin load = 1'b1; bcd_in = 16'h9999; end
                31:  begin load = 1'b1; bcd_in = 16'h5678; end  // on the boundary edge
                70:  begin load = 1'b1; bcd_in = 16'h0042; end
                110: begin load = 1'b1; bcd_in = 16'h0000; end
                150: begin load = 1'b1; bcd_in = 16'h00A7; end
                default: load = (k > 180) && ($urandom_range(0, 7) == 0);
            endcase
        end else begin
            load = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic run_cycles(input int run, input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs(run);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Asynchronous reset with a value pending; outputs must clear at once.
    task automatic mid_reset();
        load = 1'b1;
        bcd_in = 16'h3141;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("pending_before_reset", {15'd0, ready}, 16'd0);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_an",      {12'd0, an},      16'h000F);
        check_val("rst_ready",   {15'd0, ready},   16'd1);
        check_val("rst_bcd_seg", {12'd0, bcd_seg}, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run_cycles(0, 400);
        mid_reset();
        run_cycles(1, 600);
        mid_reset();
        run_cycles(2, 600);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
